sensor_scan_controller: RTL and testbench

//  Sequences the board-sensor parallel-in/serial-out shift-register chain:
//   - generates the shift clock and the active-low parallel-load strobe;
//   - serially captures NUM_BITS sensor bits and applies the forced-bit mask;
//   - debounces across scans.

---
 rtl/sensor_scan_controller_pkg.sv | 16 +
 rtl/sensor_scan_controller_if.sv | 24 ++
 rtl/sensor_scan_controller_sr_tick_gen.sv | 28 ++
 rtl/sensor_scan_controller.sv | 148 ++++++++++++++
 tb/tb_sensor_scan_controller.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_scan_controller_pkg.sv
// Shared state encoding and default chain constants for the sensor scan controller.
package sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT,
    ST_GAP
  } scan_state_t;

  localparam int          DEF_CLK_DIV    = 100;
  localparam logic [31:0] DEF_FORCE_MASK = 32'h0800_0000;
  localparam logic [31:0] DEF_FORCE_VAL  = 32'h0800_0000;

endpackage

// File: rtl/sensor_scan_controller_if.sv
// Chain-side and CPU-side signals of the scan controller; master = controller view.
interface sensor_scan_controller_if #(
  parameter int NUM_BITS = 32
);
  logic                scan_en;
  logic                sr_data;
  logic                sr_clk;
  logic                sr_load_n;
  logic [NUM_BITS-1:0] frame_data;
  logic                scan_done;
  logic                changed;
  logic                ack;
  logic                busy;

  modport master (
    input  scan_en, sr_data, ack,
    output sr_clk, sr_load_n, frame_data, scan_done, changed, busy
  );

  modport slave (
    output scan_en, sr_data, ack,
    input  sr_clk, sr_load_n, frame_data, scan_done, changed, busy
  );
endinterface

// File: rtl/sensor_scan_controller_sr_tick_gen.sv
// Clock divider: tick is high for one clk every CLK_DIV clks; restart zeroes the phase.
module sr_tick_gen
  import sensor_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);
  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/sensor_scan_controller.sv
// Scans the sensor PISO chain, debounces successive scans and publishes a sticky-flagged frame.
// Scan = (2 + 2*NUM_BITS) ticks to COMMIT, then SCAN_GAP idle ticks; frame updates at the end of COMMIT.
module sensor_scan_controller
  import sensor_pkg::*;
#(
  parameter int                  CLK_DIV    = DEF_CLK_DIV,
  parameter int                  NUM_BITS   = 32,
  parameter int                  SCAN_GAP   = 256,
  parameter int                  DEBOUNCE   = 2,
  parameter logic [NUM_BITS-1:0] FORCE_MASK = NUM_BITS'(DEF_FORCE_MASK),
  parameter logic [NUM_BITS-1:0] FORCE_VAL  = NUM_BITS'(DEF_FORCE_VAL)
) (
  input logic                      clk,
  input logic                      reset_n,
  sensor_scan_controller_if.master bus
);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam int GW = $clog2(SCAN_GAP + 1);
  localparam int SW = $clog2(DEBOUNCE + 1);

  localparam logic [BW-1:0]       BIT_LAST   = BW'(NUM_BITS);
  localparam logic [GW-1:0]       GAP_LAST   = GW'(SCAN_GAP - 1);
  localparam logic [SW-1:0]       STABLE_MAX = SW'(DEBOUNCE - 1);
  localparam logic [NUM_BITS-1:0] RST_FRAME  = FORCE_VAL & FORCE_MASK;

  scan_state_t         state;
  logic                tick;
  logic                restart;
  logic                sr_clk;
  logic                sr_load_n;
  logic                scan_done;
  logic                changed;
  logic                busy;
  logic [BW-1:0]       bit_cnt;
  logic [GW-1:0]       gap_cnt;
  logic [SW-1:0]       stable_cnt;
  logic [SW-1:0]       stable_nxt;
  logic [NUM_BITS-1:0] raw;
  logic [NUM_BITS-1:0] cand;
  logic [NUM_BITS-1:0] prev_cand;
  logic [NUM_BITS-1:0] frame_data;

  assign restart = (state == ST_IDLE) && bus.scan_en;

  sr_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .tick    (tick)
  );

  // Sensors are active-low on the chain; frame bits are 1 = occupied.
  assign cand = (~raw & ~FORCE_MASK) | (FORCE_VAL & FORCE_MASK);

  always_comb begin
    stable_nxt = '0;
    if (cand == prev_cand) begin
      stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sr_clk     <= 1'b0;
      sr_load_n  <= 1'b1;
      scan_done  <= 1'b0;
      changed    <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      stable_cnt <= '0;
      raw        <= '0;
      prev_cand  <= RST_FRAME;
      frame_data <= RST_FRAME;
    end else begin
      scan_done <= 1'b0;
      if (bus.ack) changed <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.scan_en) begin
            state     <= ST_LOAD;
            sr_load_n <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Load is held across one full sr_clk period: rising tick, then falling tick.
          if (tick) begin
            sr_clk <= ~sr_clk;
            if (sr_clk) begin
              state     <= ST_SHIFT;
              sr_load_n <= 1'b1;
              bit_cnt   <= '0;
            end
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            sr_clk <= ~sr_clk;
            if (!sr_clk) begin
              raw     <= {bus.sr_data, raw[NUM_BITS-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
            end else if (bit_cnt == BIT_LAST) begin
              state     <= ST_COMMIT;
              busy      <= 1'b0;
              scan_done <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          prev_cand  <= cand;
          stable_cnt <= stable_nxt;
          // A fresh update beats a coincident ack.
          if (stable_nxt == STABLE_MAX && cand != frame_data) begin
            frame_data <= cand;
            changed    <= 1'b1;
          end
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              if (bus.scan_en) begin
                state     <= ST_LOAD;
                sr_load_n <= 1'b0;
                busy      <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sr_clk     = sr_clk;
  assign bus.sr_load_n  = sr_load_n;
  assign bus.scan_done  = scan_done;
  assign bus.changed    = changed;
  assign bus.busy       = busy;
  assign bus.frame_data = frame_data;
endmodule

// File: tb/tb_sensor_scan_controller.sv
// Directed bench for sensor_scan_controller with a PISO chain model and a scan-timeline reference model.
module tb_sensor_scan_controller;
  localparam int             NB         = 8;
  localparam int             DIV        = 4;
  localparam int             GAP        = 3;
  localparam int             DEB        = 2;
  localparam logic [NB-1:0]  MASK       = 8'h08;
  localparam logic [NB-1:0]  FVAL       = 8'h08;
  localparam logic [NB-1:0]  RST_FRAME  = MASK & FVAL;
  localparam int             LOAD_CLK   = 2 * DIV;
  localparam int             SCAN_CLK   = (2 + 2 * NB) * DIV;
  localparam int             PERIOD_CLK = SCAN_CLK + GAP * DIV;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sensor_scan_controller_if #(.NUM_BITS(NB)) bus ();

  sensor_scan_controller #(
    .CLK_DIV(DIV), .NUM_BITS(NB), .SCAN_GAP(GAP), .DEBOUNCE(DEB),
    .FORCE_MASK(MASK), .FORCE_VAL(FVAL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Chain: parallel load while sr_load_n is low, shift towards bit 0 on sr_clk rising.
  logic [NB-1:0] chain_raw;
  logic [NB-1:0] chain;
  always @(posedge bus.sr_clk or negedge bus.sr_load_n) begin
    if (!bus.sr_load_n) chain <= chain_raw;
    else                chain <= {1'b1, chain[NB-1:1]};
  end
  assign bus.sr_data = chain[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the scan period, plus a history of the last DEB candidates.
  bit            m_run;
  int            m_t;
  bit            m_changed;
  bit            m_upd;
  bit            m_same;
  logic [NB-1:0] m_loaded;
  logic [NB-1:0] m_cand;
  logic [NB-1:0] m_frame;
  logic [NB-1:0] m_hist[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run     = 1'b0;
      m_t       = 0;
      m_frame   = RST_FRAME;
      m_changed = 1'b0;
      m_hist    = {RST_FRAME};
    end else begin
      m_upd = 1'b0;
      if (!m_run) begin
        if (bus.scan_en) begin
          m_run = 1'b1;
          m_t   = 0;
        end
      end else begin
        if (m_t == DIV) m_loaded = chain_raw;
        if (m_t == SCAN_CLK) begin
          m_cand = (~m_loaded & ~MASK) | (FVAL & MASK);
          m_hist.push_back(m_cand);
          if (m_hist.size() > DEB) void'(m_hist.pop_front());
          m_same = (m_hist.size() == DEB);
          foreach (m_hist[i]) if (m_hist[i] != m_cand) m_same = 1'b0;
          if (m_same && m_cand != m_frame) begin
            m_frame = m_cand;
            m_upd   = 1'b1;
          end
        end
        m_t++;
        if (m_t == PERIOD_CLK) begin
          if (bus.scan_en) m_t = 0;
          else             m_run = 1'b0;
        end
      end
      if (m_upd)        m_changed = 1'b1;
      else if (bus.ack) m_changed = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("m_busy",      bus.busy,      32'(m_run && m_t < SCAN_CLK));
      check("m_sr_load_n", bus.sr_load_n, 32'(!(m_run && m_t < LOAD_CLK)));
      check("m_sr_clk",    bus.sr_clk,    32'(m_run && m_t < SCAN_CLK && ((m_t / DIV) % 2 == 1)));
      check("m_scan_done", bus.scan_done, 32'(m_run && m_t == SCAN_CLK));
      check("m_frame",     bus.frame_data, 32'(m_frame));
      check("m_changed",   bus.changed,   32'(m_changed));
    end
  end

  // Waits for a load, then returns on the negedge where scan_done is high (or at abort_at).
  task automatic run_scan(input int drop_at, input int abort_at,
                          output int load_low, output int rises, output int done_at);
    bit found;
    bit prev;
    int cyc;
    load_low = 0;
    rises    = 0;
    done_at  = -1;
    found    = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!bus.sr_load_n) found = 1'b1;
    end
    check("load_start_seen", 32'(found), 1);
    prev = bus.sr_clk;
    cyc  = 0;
    while (cyc < 200) begin
      if (cyc == drop_at) bus.scan_en = 1'b0;
      if (cyc == abort_at) return;
      if (!bus.sr_load_n) load_low++;
      if (bus.sr_clk && !prev && bus.sr_load_n) rises++;
      prev = bus.sr_clk;
      if (bus.scan_done) begin
        done_at = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("scan_done_seen", 32'(done_at >= 0), 1);
  endtask

  task automatic scan(input logic [NB-1:0] raw);
    int a, b, c;
    chain_raw = raw;
    run_scan(-1, -1, a, b, c);
  endtask

  task automatic post(input logic [NB-1:0] f, input bit ch, input string tag);
    @(negedge clk);
    check({tag, "_frame"}, bus.frame_data, 32'(f));
    check({tag, "_changed"}, bus.changed, 32'(ch));
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int ll, rr, dd;

  initial begin
    reset_n     = 1'b0;
    bus.scan_en = 1'b0;
    bus.ack     = 1'b0;
    chain_raw   = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_sr_clk",    bus.sr_clk,     0);
    check("rst_sr_load_n", bus.sr_load_n,  1);
    check("rst_frame",     bus.frame_data, 32'h08);
    check("rst_scan_done", bus.scan_done,  0);
    check("rst_changed",   bus.changed,    0);
    check("rst_busy",      bus.busy,       0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_no_load", bus.sr_load_n, 1);

    // 1: all sensors idle.
    bus.scan_en = 1'b1;
    run_scan(-1, -1, ll, rr, dd);
    check("t1_load_low_clks", ll, 8);
    check("t1_shift_rises",   rr, 8);
    check("t1_done_clk",      dd, 72);
    post(8'h08, 1'b0, "t1");

    // 2: sensor 0 occupied for two scans.
    scan(8'hFE); post(8'h08, 1'b0, "t2_first");
    scan(8'hFE); post(8'h09, 1'b1, "t2_second");
    pulse_ack();
    check("t2_ack_clears", bus.changed, 0);

    // 3: flicker never settles.
    for (int i = 0; i < 4; i++) begin
      scan((i % 2 == 1) ? 8'hFE : 8'hFF);
      post(8'h09, 1'b0, "t3_flicker");
    end

    // 4: ack coinciding with a new update loses.
    scan(8'hF0); post(8'h09, 1'b0, "t4_a");
    scan(8'hF0); post(8'h0F, 1'b1, "t4_b");
    scan(8'hFF); post(8'h0F, 1'b1, "t4_c");
    scan(8'hFF);
    pulse_ack();
    check("t4_set_wins_frame",   bus.frame_data, 32'h08);
    check("t4_set_wins_changed", bus.changed,    1);
    pulse_ack();
    check("t4_ack_alone", bus.changed, 0);
    pulse_ack();
    check("t4_ack_idle_noop", bus.changed, 0);

    // 5: scan_en dropped mid-SHIFT.
    chain_raw = 8'hFF;
    run_scan(20, -1, ll, rr, dd);
    check("t5_done_clk",      dd, 72);
    check("t5_done_rises",    rr, 8);
    repeat (3) @(negedge clk);
    check("t5_gap_busy", bus.busy, 0);
    repeat (9) @(negedge clk);
    check("t5_idle_sr_clk",    bus.sr_clk,    0);
    check("t5_idle_sr_load_n", bus.sr_load_n, 1);
    check("t5_idle_busy",      bus.busy,      0);
    repeat (30) @(negedge clk);
    check("t5_stays_idle", bus.sr_load_n, 1);

    // 6: reset mid-SHIFT, then a clean capture.
    bus.scan_en = 1'b1;
    scan(8'h00); post(8'h08, 1'b0, "t6_pre1");
    scan(8'h00); post(8'hFF, 1'b1, "t6_pre2");
    chain_raw = 8'h5A;
    run_scan(-1, 30, ll, rr, dd);
    check("t6_mid_shift_sr_clk", bus.sr_clk, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_sr_clk",    bus.sr_clk,     0);
    check("t6_rst_sr_load_n", bus.sr_load_n,  1);
    check("t6_rst_busy",      bus.busy,       0);
    check("t6_rst_frame",     bus.frame_data, 32'h08);
    check("t6_rst_changed",   bus.changed,    0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    scan(8'h5A); post(8'h08, 1'b0, "t6_after1");
    scan(8'h5A); post(8'hAD, 1'b1, "t6_after2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
